// File: rtl/experiment_pkg.sv
// Shared definitions for the experiment sequencer: opcodes, FSM encoding, command fields, status layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package experiment_pkg;

    // Command word layout
    localparam int CMD_W      = 16;
    localparam int CNT_W      = 14;
    localparam int NUM_DAC    = 3;
    localparam int NUM_ADC    = 2;

    typedef enum logic [1:0] {
        OP_END  = 2'b00,
        OP_PLAY = 2'b01,
        OP_CAPT = 2'b10,
        OP_WAIT = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PLAY  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Status word layout, LSB first: busy, done, err, fifo count, retired, beats
    localparam int ST_FCNT_W  = 7;
    localparam int ST_RET_W   = 8;
    localparam int ST_BEAT_W  = 14;

    // A beat happens only when every stream selected by the mask is ready.
    function automatic logic mask_hit(input logic [2:0] rdy, input logic [2:0] mask);
        return (rdy & mask) == mask;
    endfunction

endpackage

// File: rtl/seq_cmd_fifo.sv
// First-word-fall-through command FIFO with occupancy count and synchronous flush.
// Latency: a pushed word is visible at head_dat_o the cycle after the push.
// Backpressure: pushes while full and pops while empty are dropped; flush wins over push/pop.
module seq_cmd_fifo #(
    parameter int CMD_DEPTH = 16,
    parameter int W         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_dat_o,
    output logic                       empty_o,
    output logic [$clog2(CMD_DEPTH):0] count_o
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [CMD_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, push_ok, pop_ok;

    assign full    = (count_q == CW'(CMD_DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/experiment_sequencer.sv
// Command-driven scheduler gating DAC playback (A/B/C) and ADC capture (MAC/NL) from a buffered command stream.
// Latency: start edge at cycle N -> FETCH at N+1 -> enables high at N+2; one FETCH bubble between commands.
// Backpressure: s_axis_tready registered, low when the FIFO will be full or while abort is held; optional beat counter under EXPERIMENT_SEQ_BEAT_COUNT_EN.
module experiment_sequencer
    import experiment_pkg::*;
#(
    parameter int CMD_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out_bus,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [2:0]  dac_tready,
    output logic [2:0]  dac_en,
    input  logic [1:0]  adc_tvalid,
    output logic [1:0]  adc_en
);

    localparam int FCW = $clog2(CMD_DEPTH) + 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_DAC-1:0]   dmask_q, dmask_d;
    logic [NUM_ADC-1:0]   amask_q, amask_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [ST_RET_W-1:0]  retired_q, retired_d;
    logic [NUM_DAC-1:0]   dac_en_q, dac_en_d;
    logic [NUM_ADC-1:0]   adc_en_q, adc_en_d;
    logic                 busy_q, busy_d;
    logic                 tready_q, tready_d;
    logic                 start_q;

    logic                 abort, start_edge, start_ok;
    logic                 push, pop;
    logic                 play_hit, capt_hit;
    logic [CMD_W-1:0]     fifo_head;
    logic                 fifo_empty;
    logic [FCW-1:0]       fifo_cnt, fcnt_nxt;
    logic [ST_BEAT_W-1:0] beat_field;
    logic                 unused_gpio;

    assign abort       = gpio_in[1];
    assign start_edge  = gpio_in[0] && !start_q;
    assign start_ok    = start_edge && (state_q == ST_IDLE || state_q == ST_DONE);
    assign push        = s_axis_tvalid && tready_q;
    assign play_hit    = mask_hit(dac_tready, dmask_q);
    assign capt_hit    = mask_hit({1'b0, adc_tvalid}, {1'b0, amask_q});
    assign unused_gpio = ^gpio_in[31:2];

    seq_cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH),
        .W         (CMD_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (abort),
        .push_i     (push),
        .push_dat_i (s_axis_tdata),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    // Next FSM state, counters and flags; abort overrides every other transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dmask_d   = dmask_q;
        amask_d   = amask_q;
        done_d    = done_q;
        err_d     = err_q;
        retired_d = retired_q;
        pop       = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_d = ST_FETCH;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        case (opcode_e'(fifo_head[15:14]))
                            OP_END: begin
                                state_d   = ST_DONE;
                                done_d    = 1'b1;
                                retired_d = retired_q + 8'd1;
                            end
                            OP_PLAY: begin
                                state_d = ST_PLAY;
                                dmask_d = fifo_head[13:11];
                                cnt_d   = {3'b000, fifo_head[10:0]};
                                // Empty mask is a malformed command: flag it and run as a NOP.
                                if (fifo_head[13:11] == '0) begin
                                    err_d = 1'b1;
                                    cnt_d = '0;
                                end
                            end
                            OP_CAPT: begin
                                state_d = ST_CAPT;
                                amask_d = fifo_head[13:12];
                                cnt_d   = {2'b00, fifo_head[11:0]};
                                if (fifo_head[13:12] == '0) begin
                                    err_d = 1'b1;
                                    cnt_d = '0;
                                end
                            end
                            default: begin
                                state_d = ST_WAIT;
                                cnt_d   = fifo_head[13:0];
                            end
                        endcase
                    end
                end
                ST_PLAY, ST_CAPT, ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d   = ST_FETCH;
                        retired_d = retired_q + 8'd1;
                    end else if ((state_q == ST_WAIT) ||
                                 (state_q == ST_PLAY && play_hit) ||
                                 (state_q == ST_CAPT && capt_hit)) begin
                        cnt_d = cnt_q - 14'd1;
                        if (cnt_q == 14'd1) begin
                            state_d   = ST_FETCH;
                            retired_d = retired_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Registered outputs derived from next state so they align with the state they describe.
    always_comb begin
        dac_en_d = '0;
        adc_en_d = '0;
        if (state_d == ST_PLAY && cnt_d != '0) dac_en_d = dmask_d;
        if (state_d == ST_CAPT && cnt_d != '0) adc_en_d = amask_d;
        busy_d   = !(state_d == ST_IDLE || state_d == ST_DONE);
        fcnt_nxt = fifo_cnt + FCW'(push) - FCW'(pop);
        tready_d = !abort && (fcnt_nxt != FCW'(CMD_DEPTH));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dmask_q   <= '0;
            amask_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
            dac_en_q  <= '0;
            adc_en_q  <= '0;
            busy_q    <= 1'b0;
            tready_q  <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dmask_q   <= dmask_d;
            amask_q   <= amask_d;
            done_q    <= done_d;
            err_q     <= err_d;
            retired_q <= retired_d;
            dac_en_q  <= dac_en_d;
            adc_en_q  <= adc_en_d;
            busy_q    <= busy_d;
            tready_q  <= tready_d;
            start_q   <= gpio_in[0];
        end
    end

`ifdef EXPERIMENT_SEQ_BEAT_COUNT_EN
    logic [ST_BEAT_W-1:0] beats_q, beats_d;
    logic                 beat;

    assign beat = !abort && (cnt_q != '0) &&
                  ((state_q == ST_PLAY && play_hit) || (state_q == ST_CAPT && capt_hit));

    // Saturating count of PLAY/CAPT beats since the last accepted start.
    always_comb begin
        beats_d = beats_q;
        if (abort || start_ok)          beats_d = '0;
        else if (beat && beats_q != '1) beats_d = beats_q + 14'd1;
    end

    // Beat counter register.
    always_ff @(posedge clk) begin
        if (rst) beats_q <= '0;
        else     beats_q <= beats_d;
    end

    assign beat_field = beats_q;
`else
    assign beat_field = '0;
`endif

    assign gpio_out_bus  = {beat_field, retired_q, ST_FCNT_W'(fifo_cnt), err_q, done_q, busy_q};
    assign s_axis_tready = tready_q;
    assign dac_en        = dac_en_q;
    assign adc_en        = adc_en_q;

endmodule

// File: tb/tb_experiment_sequencer.sv
// Directed + randomized bench for experiment_sequencer against a trace-predicting reference model.
// Latency: expected enable traces are built per slot, slot 0 being the FETCH cycle after the start edge.
// Backpressure: pushes wait (bounded) for s_axis_tready.
module tb_experiment_sequencer;

    localparam int MAXS = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out_bus;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [2:0]  dac_tready;
    logic [2:0]  dac_en;
    logic [1:0]  adc_tvalid;
    logic [1:0]  adc_en;

    int n_cmp  = 0;
    int n_fail = 0;
    int tot_ret = 0;

    logic [15:0] prog[$];
    logic [2:0]  dpat[MAXS];
    logic [1:0]  apat[MAXS];
    logic [2:0]  exp_dac[MAXS];
    logic [1:0]  exp_adc[MAXS];
    int          done_slot, exp_beats, n_ret;
    logic        exp_err;

    experiment_sequencer #(.CMD_DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .gpio_in       (gpio_in),
        .gpio_out_bus  (gpio_out_bus),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .dac_tready    (dac_tready),
        .dac_en        (dac_en),
        .adc_tvalid    (adc_tvalid),
        .adc_en        (adc_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        int n;
        n = 0;
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 64) begin
            step();
            n++;
        end
        chk("push_ready", s_axis_tready, 1);
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic default_pats();
        for (int s = 0; s < MAXS; s++) begin
            dpat[s] = 3'b111;
            apat[s] = 2'b11;
        end
    endtask

    // Predict the per-slot enable trace: each command costs one FETCH slot, then its
    // exec slots; a PLAY/CAPT holds its mask until the len-th cycle on which all masked
    // streams are ready; WAIT takes max(len,1) slots; END lands in DONE.
    task automatic build_trace();
        int s, rem, len;
        logic [15:0] w;
        logic [2:0]  m3;
        logic [1:0]  m2;
        for (int i = 0; i < MAXS; i++) begin
            exp_dac[i] = '0;
            exp_adc[i] = '0;
        end
        exp_err = 1'b0; exp_beats = 0; n_ret = 0; done_slot = 0; s = 0;
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            s++;
            n_ret++;
            if (w[15:14] == 2'b00) begin
                done_slot = s;
                break;
            end else if (w[15:14] == 2'b11) begin
                len = int'(w[13:0]);
                s += (len == 0) ? 1 : len;
            end else if (w[15:14] == 2'b01) begin
                m3 = w[13:11]; len = int'(w[10:0]);
                if (m3 == 3'b000) begin exp_err = 1'b1; len = 0; end
                if (len == 0) s++;
                rem = len;
                while (rem > 0 && s < MAXS - 1) begin
                    exp_dac[s] = m3;
                    if ((dpat[s] & m3) == m3) begin rem--; exp_beats++; end
                    s++;
                end
            end else begin
                m2 = w[13:12]; len = int'(w[11:0]);
                if (m2 == 2'b00) begin exp_err = 1'b1; len = 0; end
                if (len == 0) s++;
                rem = len;
                while (rem > 0 && s < MAXS - 1) begin
                    exp_adc[s] = m2;
                    if ((apat[s] & m2) == m2) begin rem--; exp_beats++; end
                    s++;
                end
            end
        end
    endtask

    // Load prog, start, and compare enables/busy slot by slot, then the final status.
    task automatic run(input string tag);
        foreach (prog[i]) push_word(prog[i]);
        chk({tag, ":fifo_count"}, gpio_out_bus[9:3], prog.size());
        build_trace();
        gpio_in[0] = 1'b1;
        step();
        gpio_in[0] = 1'b0;
        for (int s = 0; s <= done_slot; s++) begin
            dac_tready = dpat[s];
            adc_tvalid = apat[s];
            // a second start edge while busy must change nothing
            if (done_slot > 4 && s == 2) gpio_in[0] = 1'b1;
            if (s == 4) gpio_in[0] = 1'b0;
            chk({tag, ":dac_en"}, dac_en, exp_dac[s]);
            chk({tag, ":adc_en"}, adc_en, exp_adc[s]);
            chk({tag, ":busy"}, gpio_out_bus[0], (s < done_slot));
            if (s < done_slot) step();
        end
        tot_ret += n_ret;
        chk({tag, ":done"}, gpio_out_bus[1], 1);
        chk({tag, ":err"}, gpio_out_bus[2], exp_err);
        chk({tag, ":fifo_empty"}, gpio_out_bus[9:3], 0);
        chk({tag, ":retired"}, gpio_out_bus[17:10], tot_ret % 256);
`ifdef EXPERIMENT_SEQ_BEAT_COUNT_EN
        chk({tag, ":beats"}, gpio_out_bus[31:18], exp_beats);
`else
        chk({tag, ":beats"}, gpio_out_bus[31:18], 0);
`endif
        gpio_in[0] = 1'b0;
        prog.delete();
    endtask

    initial begin
        int n;
        int ncmd;
        int op;
        int len;
        rst = 1'b1; gpio_in = '0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        dac_tready = '0; adc_tvalid = '0;

        // Reset behaviour
        step(); step(); step();
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_status", gpio_out_bus, 0);
        chk("rst_dac_en", dac_en, 0);
        chk("rst_adc_en", adc_en, 0);
        rst = 1'b0;
        step();
        chk("post_rst_tready", s_axis_tready, 1);
        chk("post_rst_status", gpio_out_bus, 0);

        // PLAY A length 5 with all ready, then END
        default_pats();
        prog.push_back(16'h4805); prog.push_back(16'h0000);
        run("play_a5");

        // PLAY A+C length 3 with C ready only on even slots
        default_pats();
        for (int s = 0; s < MAXS; s++) dpat[s] = (s % 2 == 1) ? 3'b011 : 3'b111;
        prog.push_back(16'h6803); prog.push_back(16'h0000);
        run("play_ac_toggle");

        // CAPTURE MAC+NL length 4; NL not valid for the first slots
        default_pats();
        for (int s = 0; s <= 10; s++) apat[s] = 2'b01;
        prog.push_back(16'hB004); prog.push_back(16'h0000);
        run("capt_both4");

        // Zero-mask PLAY flags err and the following command still runs
        default_pats();
        prog.push_back(16'h4003); prog.push_back(16'h4802); prog.push_back(16'h0000);
        run("mask0");

        // PLAY 5 + CAPTURE 4 beat total
        default_pats();
        prog.push_back(16'h4805); prog.push_back(16'h9004); prog.push_back(16'h0000);
        run("beats9");

        // Push and pop in the same cycle keep the count unchanged
        push_word(16'hC002);
        chk("pp_count_before", gpio_out_bus[9:3], 1);
        gpio_in[0] = 1'b1;
        step();
        gpio_in[0] = 1'b0;
        s_axis_tdata = 16'h0000; s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        chk("pp_count_same", gpio_out_bus[9:3], 1);
        n = 0;
        while (!gpio_out_bus[1] && n < 20) begin step(); n++; end
        chk("pp_done", gpio_out_bus[1], 1);
        chk("pp_fifo_empty", gpio_out_bus[9:3], 0);
        tot_ret += 2;
        chk("pp_retired", gpio_out_bus[17:10], tot_ret % 256);

        // Fill FIFO to capacity, then abort a long PLAY
        for (int i = 0; i < 16; i++) push_word(i == 0 ? 16'h4864 : 16'hC000);
        chk("full_tready", s_axis_tready, 0);
        chk("full_count", gpio_out_bus[9:3], 16);
        dac_tready = 3'b111;
        gpio_in[0] = 1'b1;
        step();
        gpio_in[0] = 1'b0;
        step();
        chk("after_pop_count", gpio_out_bus[9:3], 15);
        chk("after_pop_tready", s_axis_tready, 1);
        chk("long_play_en", dac_en, 3'b001);
        s_axis_tdata = 16'hC000; s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        chk("refill_count", gpio_out_bus[9:3], 16);
        chk("refill_tready", s_axis_tready, 0);
        gpio_in[1] = 1'b1;
        step();
        chk("abort_dac_en", dac_en, 0);
        chk("abort_count", gpio_out_bus[9:3], 0);
        chk("abort_busy", gpio_out_bus[0], 0);
        chk("abort_tready", s_axis_tready, 0);
        step();
        chk("abort_held_tready", s_axis_tready, 0);
        gpio_in[1] = 1'b0;
        step();
        chk("abort_rel_tready", s_axis_tready, 1);
        chk("abort_rel_flags", gpio_out_bus[2:0], 0);

        // Randomized programs against the trace model
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < MAXS; s++) begin
                dpat[s] = {($urandom_range(3) != 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0)};
                apat[s] = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
            end
            ncmd = int'($urandom_range(2, 6));
            for (int c = 0; c < ncmd; c++) begin
                op  = int'($urandom_range(1, 3));
                len = int'($urandom_range(0, 6));
                if (op == 1)      prog.push_back({2'b01, 3'($urandom_range(0, 7)), 11'(len)});
                else if (op == 2) prog.push_back({2'b10, 2'($urandom_range(0, 3)), 12'(len)});
                else              prog.push_back({2'b11, 14'(len)});
            end
            prog.push_back(16'h0000);
            run($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
